// File: rtl/reg_file.sv
// rv32i integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional macro REG_FILE_BYPASS_EN adds write-through forwarding on both read ports.
module reg_file #(
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_reg1,
  input  logic [ADDR_WIDTH-1:0] rd_reg2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // x0 has no storage, so the arrays start at index 1
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_reg == ADDR_WIDTH'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read mux defaults to zero, which also covers the x0 case
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_reg1 == ADDR_WIDTH'(i)) begin
        rd_data1 = regs_q[i];
      end
      if (rd_reg2 == ADDR_WIDTH'(i)) begin
        rd_data2 = regs_q[i];
      end
    end
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && wr_en && (wr_reg != '0)) begin
      if (rd_reg1 == wr_reg) begin
        rd_data1 = wr_data;
      end
      if (rd_reg2 == wr_reg) begin
        rd_data2 = wr_data;
      end
    end
`else
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read values, a negedge monitor pops and compares.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } exp_t;

  exp_t sb_q[$];
  int   checks_total;
  int   checks_passed;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [31:0] RDW_PRE = 32'h0000_0002;
`else
  localparam logic [31:0] RDW_PRE = 32'h0000_0001;
`endif

  reg_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .rd_reg1 (rd_reg1),
    .rd_reg2 (rd_reg2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: read ports are combinational, so every queued expectation is checked at the next negedge
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks_total++;
      if (rd_data1 === e.exp1 && rd_data2 === e.exp2) begin
        checks_passed++;
      end else begin
        $display("[TB] FAIL %s: rd_data1=%h rd_data2=%h, expected %h %h",
                 e.name, rd_data1, rd_data2, e.exp1, e.exp2);
      end
    end
  end

  task automatic applyStimulus(input logic wen, input logic [4:0] wreg, input logic [31:0] wdata,
                               input logic [4:0] r1, input logic [4:0] r2);
    wr_en   = wen;
    wr_reg  = wreg;
    wr_data = wdata;
    rd_reg1 = r1;
    rd_reg2 = r2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    sb_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] wreg, input logic [31:0] wdata);
    applyStimulus(1'b1, wreg, wdata, 5'd0, 5'd0);
    nextCycle();
  endtask

  initial begin
    int wait_cycles;
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    nextCycle();

    // Reset state
    applyStimulus(1'b1, 5'd5, 32'h1111_1111, 5'd5, 5'd0);
    checkOutput("reset_x5_x0", 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    checkOutput("reset_x1_x31", 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle clears x5
    writeReg(5'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checkOutput("x5_written", 32'hDEAD_BEEF, 32'h0);
    nextCycle();
    rst_n = 1'b0;
    checkOutput("async_reset_x5", 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;

    // Write then read on both ports, including top index
    writeReg(5'd1, 32'h1234_5678);
    writeReg(5'd31, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    checkOutput("wr_x1_x31", 32'h1234_5678, 32'hFFFF_FFFF);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    checkOutput("swap_ports", 32'hFFFF_FFFF, 32'h1234_5678);
    nextCycle();

    // x0 write discard; x0 stays zero even while a write to x0 is presented
    applyStimulus(1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0);
    checkOutput("x0_during_write", 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("x0_after_write", 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd5);
    checkOutput("x0_wr_no_side_effect", 32'h1234_5678, 32'h0);
    nextCycle();

    // Write-enable low holds x7
    writeReg(5'd7, 32'h0000_0011);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd7, 32'h0000_0022, 5'd7, 5'd7);
      checkOutput($sformatf("wen_low_x7_%0d", i), 32'h0000_0011, 32'h0000_0011);
      nextCycle();
    end

    // Read-during-write on x9
    writeReg(5'd9, 32'h0000_0001);
    applyStimulus(1'b1, 5'd9, 32'h0000_0002, 5'd9, 5'd9);
    checkOutput("rdw_x9_pre", RDW_PRE, RDW_PRE);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("rdw_x9_post", 32'h0000_0002, 32'h0000_0002);
    nextCycle();

    // Reset held across an edge with a pending write to x3
    writeReg(5'd3, 32'h0000_0055);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    checkOutput("x3_written", 32'h0000_0055, 32'h0000_0011);
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'h0000_00FF, 5'd3, 5'd3);
    checkOutput("rst_pending_pre", 32'h0, 32'h0);
    nextCycle();
    checkOutput("rst_pending_post", 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    checkOutput("rst_released_x3", 32'h0, 32'h0);
    nextCycle();

    // Post-reset write still works
    writeReg(5'd3, 32'h0000_00FF);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
    checkOutput("x3_after_reset", 32'h0000_00FF, 32'h0);
    nextCycle();

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 5) begin
      nextCycle();
      wait_cycles++;
    end
    if (sb_q.size() > 0) begin
      checks_total++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file for the single-cycle rv32i datapath, sitting directly upstream of the ALU.
- Two combinational read ports supply the ALU operand buses (in_a via rd_data1, in_b via rd_data2 or immediate mux).
- One synchronous write port accepts the writeback value, typically ALU result.
- x0 is hardwired to zero per the RISC-V ISA.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH (32)
- RESET_VALUE, 32'h0000_0000, value loaded into every register x1..xN-1 on reset

Ports:
- clk  input  1  system clock; all writes on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write enable, sampled at rising edge of clk
- wr_reg  input  ADDR_WIDTH  destination register index (rd)
- wr_data  input  DATA_WIDTH  writeback data
- rd_reg1  input  ADDR_WIDTH  read port 1 index (rs1)
- rd_reg2  input  ADDR_WIDTH  read port 2 index (rs2)
- rd_data1  output  DATA_WIDTH  contents of rd_reg1, feeds ALU in_a
- rd_data2  output  DATA_WIDTH  contents of rd_reg2, feeds ALU operand B path

Behaviour:
- Storage: 2**ADDR_WIDTH entries of DATA_WIDTH bits. Entry 0 is not a storage element; it is constant 0.
- Reset: asserting rst_n low immediately (no clock needed) sets x1..xN-1 to RESET_VALUE.
  - While rst_n is low, writes are ignored and reads return register contents, i.e. RESET_VALUE, or 0 for x0.
  - Deassertion is synchronised by the system; the block requires no extra cycles after rst_n rises.
- Write: at rising edge of clk with rst_n high, wr_en = 1 and wr_reg != 0, set reg[wr_reg] <= wr_data.
  - wr_en = 0: no state change.
  - wr_reg = 0: write silently discarded; no state change.
- Read: purely combinational, zero latency. rd_dataN = (rd_regN == 0) ? 0 : reg[rd_regN].
  - Both ports are independent and may address the same register; both return the same value.
- Write-to-read latency (base build): a value written at edge k is visible on the read ports after edge k.
  - During the cycle before edge k, a read of wr_reg returns the old value, with no forwarding.
- Reset mid-operation: rst_n falling between edges clears contents at once.
  - A write pending for the next edge is lost if rst_n is still low at that edge.
- No X propagation: every output is driven from defined storage or constant 0 at all times after reset.
- Width rules: no arithmetic. Indices are unsigned; the full 0..2**ADDR_WIDTH-1 range is valid, with no out-of-range case.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined: write-through forwarding on both read ports.
  - If wr_en = 1, wr_reg != 0 and rd_regN == wr_reg, then rd_dataN = wr_data combinationally in the same cycle, before the edge.
  - x0 reads still return 0 even when wr_reg = 0 and wr_en = 1.
  - Bypass is suppressed while rst_n is low.
- Undefined: no forwarding; read-during-write returns the pre-write value as described under Behaviour.

Test Plan:
- Reset and x0:
  - Stimulus: rst_n = 0 mid-cycle with x5 = 32'hDEAD_BEEF, then read x5 and x0.
  - Required: x5 reads 32'h0000_0000 before the next edge; x0 reads 0.
- Write then read:
  - Stimulus: write x1 = 32'h1234_5678 and x31 = 32'hFFFF_FFFF on consecutive edges, then rd_reg1 = 1, rd_reg2 = 31.
  - Required: rd_data1 = 32'h1234_5678, rd_data2 = 32'hFFFF_FFFF.
- x0 write discard:
  - Stimulus: wr_en = 1, wr_reg = 0, wr_data = 32'hA5A5_A5A5, then read x0 on both ports.
  - Required: both read 0.
- Write-enable low:
  - Stimulus: x7 = 32'h0000_0011, then wr_en = 0, wr_reg = 7, wr_data = 32'h0000_0022 for 3 edges.
  - Required: x7 still reads 32'h0000_0011.
- Read-during-write on x9 (old value 32'h0000_0001, writing 32'h0000_0002, rd_reg1 = rd_reg2 = 9):
  - Before the edge: both ports read 32'h0000_0001 without REG_FILE_BYPASS_EN, 32'h0000_0002 with it.
  - After the edge: both ports read 32'h0000_0002 in either build.
- Reset during pending write:
  - Stimulus: wr_en = 1, wr_reg = 3, wr_data = 32'h0000_00FF, rst_n held low across the edge.
  - Required: x3 reads 32'h0000_0000 after the edge and after rst_n rises.
